// File: rtl/nic_injector.sv
// Host-side injector for one ring router: accepts host packets, queues them
// and forwards one per strobe into the router's left input port.
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   host_valid/ready    host handshake; ready is !fifo_full
//   host_dest/payload   packet fields, formatted as {payload, dest}
//   net_data_out        packet towards router left_data_in (held when idle)
//   net_enable_out      one-cycle strobe towards router left_enable_in
//   net_buffer_full     router backpressure, sampled only when idle
//   fifo_level          queue occupancy
//   sent_count          packets forwarded (wraps)
//   drop_count          self/invalid-addressed packets (saturates)
module nic_injector #(
    parameter int ROUTER_ID   = 0,
    parameter int PACKET_SIZE = 8,
    parameter int ROUTER_BITS = 2,
    parameter int NUM_ROUTERS = 4,
    parameter int FIFO_DEPTH  = 4,
    parameter int MIN_GAP     = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               host_valid,
    input  logic [ROUTER_BITS-1:0]             host_dest,
    input  logic [PACKET_SIZE-ROUTER_BITS-1:0] host_payload,
    output logic                               host_ready,
    output logic [PACKET_SIZE-1:0]             net_data_out,
    output logic                               net_enable_out,
    input  logic                               net_buffer_full,
    output logic [$clog2(FIFO_DEPTH):0]        fifo_level,
    output logic [15:0]                        sent_count,
    output logic [7:0]                         drop_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] FULL_LVL = (PW + 1)'(FIFO_DEPTH);
    localparam logic [3:0] GAP_INIT = 4'(MIN_GAP);

    typedef enum logic {
        S_IDLE,
        S_GAP
    } state_t;

    logic [PACKET_SIZE-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW:0] count;

    state_t state;
    state_t state_nx;
    logic [3:0] gap_cnt;
    logic [3:0] gap_nx;

    logic [31:0] dest_ext;
    logic bad_dest;
    logic accept;
    logic push;
    logic drop;
    logic issue;

    assign host_ready = (count != FULL_LVL);
    assign fifo_level = count;

    assign dest_ext = 32'(host_dest);
    assign bad_dest = (dest_ext == 32'(ROUTER_ID)) ||
                      (dest_ext >= 32'(NUM_ROUTERS));

    assign accept = host_valid && host_ready;
    assign push   = accept && !bad_dest;
    assign drop   = accept && bad_dest;

    // Issue decision uses pre-edge occupancy, so a packet pushed at an
    // edge can only leave at the following edge (no bypass).
    always_comb begin
        state_nx = state;
        gap_nx   = gap_cnt;
        issue    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (count != '0 && !net_buffer_full) begin
                    issue = 1'b1;
                    if (GAP_INIT != 4'd0) begin
                        state_nx = S_GAP;
                        gap_nx   = GAP_INIT;
                    end
                end
            end
            S_GAP: begin
                // Leaving on the last counted cycle gives exactly MIN_GAP
                // idle cycles between strobes.
                gap_nx = gap_cnt - 4'd1;
                if (gap_cnt <= 4'd1) begin
                    state_nx = S_IDLE;
                    gap_nx   = 4'd0;
                end
            end
            default: begin
                state_nx = S_IDLE;
                gap_nx   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            gap_cnt <= 4'd0;
        end else begin
            state   <= state_nx;
            gap_cnt <= gap_nx;
        end
    end

    // Storage is not reset; clearing the pointers discards its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= {host_payload, host_dest};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (issue) begin
                head <= head + 1'b1;
            end
            if (push && !issue) begin
                count <= count + 1'b1;
            end else if (!push && issue) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            net_data_out   <= '0;
            net_enable_out <= 1'b0;
        end else begin
            net_enable_out <= issue;
            if (issue) begin
                net_data_out <= mem[head];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sent_count <= 16'd0;
            drop_count <= 8'd0;
        end else begin
            if (issue) begin
                sent_count <= sent_count + 16'd1;
            end
            if (drop && drop_count != 8'hFF) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_nic_injector.sv
// Directed bench for nic_injector with a packet scoreboard and a
// cycle-level occupancy/counter model.
module tb_nic_injector;

    localparam int MIN_GAP = 1;

    logic       clk;
    logic       rst;
    logic       host_valid;
    logic [1:0] host_dest;
    logic [5:0] host_payload;
    logic       host_ready;
    logic [7:0] net_data_out;
    logic       net_enable_out;
    logic       net_buffer_full;
    logic [2:0] fifo_level;
    logic [15:0] sent_count;
    logic [7:0] drop_count;

    nic_injector #(
        .ROUTER_ID(0),
        .PACKET_SIZE(8),
        .ROUTER_BITS(2),
        .NUM_ROUTERS(4),
        .FIFO_DEPTH(4),
        .MIN_GAP(MIN_GAP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .host_valid(host_valid),
        .host_dest(host_dest),
        .host_payload(host_payload),
        .host_ready(host_ready),
        .net_data_out(net_data_out),
        .net_enable_out(net_enable_out),
        .net_buffer_full(net_buffer_full),
        .fifo_level(fifo_level),
        .sent_count(sent_count),
        .drop_count(drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [7:0] sb[$];
    int m_level = 0;
    logic [15:0] m_sent = 0;
    int m_drop = 0;
    int ncyc = 0;
    int last_en = -100;
    int en_cnt = 0;
    int en_mark;
    bit strict_gap = 0;
    bit saw_full;
    bit acc;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    // One clock: inputs are applied at the posedge, outputs sampled at
    // the following negedge.
    task automatic cyc();
        logic a;
        logic d;
        logic [7:0] pkt;
        a = host_valid && (m_level < 4) && (host_dest != 2'd0);
        d = host_valid && (m_level < 4) && (host_dest == 2'd0);
        pkt = {host_payload, host_dest};
        @(posedge clk);
        @(negedge clk);
        ncyc++;
        if (a) begin
            sb.push_back(pkt);
            m_level++;
        end
        if (d && m_drop != 255) m_drop++;
        if (net_enable_out === 1'b1) begin
            en_cnt++;
            m_sent++;
            m_level--;
            total++;
            assert (sb.size() != 0) else begin
                bad++;
                $error("FAIL sb_empty_on_enable observed=1 expected=0");
            end
            if (sb.size() != 0) chk("pkt", 32'(net_data_out), 32'(sb.pop_front()));
            chk("gap_min", 32'((ncyc - last_en) >= MIN_GAP + 1), 1);
            if (strict_gap && last_en >= 0)
                chk("gap_exact", ncyc - last_en, MIN_GAP + 1);
            last_en = ncyc;
        end
        chk("level", 32'(fifo_level), m_level);
        chk("ready", 32'(host_ready), 32'(m_level < 4));
        chk("sent", 32'(sent_count), 32'(m_sent));
        chk("drop", 32'(drop_count), m_drop);
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && sb.size() != 0; k++) cyc();
        chk("drain_empty", sb.size(), 0);
    endtask

    initial begin
        rst = 1'b1;
        host_valid = 1'b0;
        host_dest = 2'd0;
        host_payload = 6'd0;
        net_buffer_full = 1'b0;

        // Reset without any clock edge
        #1 rst = 1'b0;
        #2;
        chk("rst_data", 32'(net_data_out), 0);
        chk("rst_en", 32'(net_enable_out), 0);
        chk("rst_ready", 32'(host_ready), 1);
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_sent", 32'(sent_count), 0);
        chk("rst_drop", 32'(drop_count), 0);
        for (int i = 0; i < 3; i++) cyc();
        #1 rst = 1'b1;

        // Single packet: {6'h15, 2'd2} = 8'h56
        host_valid = 1'b1;
        host_dest = 2'd2;
        host_payload = 6'h15;
        en_mark = en_cnt;
        cyc();
        host_valid = 1'b0;
        chk("single_no_early_en", en_cnt - en_mark, 0);
        chk("single_level1", 32'(fifo_level), 1);
        cyc();
        chk("single_en", en_cnt - en_mark, 1);
        chk("single_data", 32'(net_data_out), 32'h56);
        chk("single_sent", 32'(sent_count), 1);
        cyc();
        chk("single_en_one_cycle", 32'(net_enable_out), 0);
        chk("single_hold_data", 32'(net_data_out), 32'h56);

        // Burst of 8 with host_valid held, no backpressure
        saw_full = 0;
        last_en = -100;
        strict_gap = 1;
        host_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            host_dest = 2'(1 + i % 3);
            host_payload = 6'(i * 5 + 1);
            acc = 0;
            for (int k = 0; k < 20 && !acc; k++) begin
                acc = (m_level < 4);
                if (host_ready === 1'b0) saw_full = 1;
                cyc();
            end
            chk("burst_accept", 32'(acc), 1);
        end
        host_valid = 1'b0;
        drain();
        strict_gap = 0;
        chk("burst_saw_full", 32'(saw_full), 1);
        chk("burst_sent", 32'(sent_count), 9);

        // Backpressure: 4 queued, router full for 10 cycles
        net_buffer_full = 1'b1;
        host_valid = 1'b1;
        en_mark = en_cnt;
        for (int i = 0; i < 4; i++) begin
            host_dest = 2'(3 - i % 3);
            host_payload = 6'(6'h30 + i);
            cyc();
        end
        host_dest = 2'd1;
        host_payload = 6'h3F;
        for (int i = 0; i < 10; i++) cyc();
        host_valid = 1'b0;
        chk("bp_no_enable", en_cnt - en_mark, 0);
        chk("bp_level", 32'(fifo_level), 4);
        chk("bp_ready", 32'(host_ready), 0);
        net_buffer_full = 1'b0;
        en_mark = en_cnt;
        cyc();
        chk("bp_release_latency", en_cnt - en_mark, 1);
        drain();

        // Drops: self-addressed packets never reach the router
        en_mark = en_cnt;
        host_valid = 1'b1;
        host_dest = 2'd0;
        host_payload = 6'h01;
        cyc();
        chk("drop_one", 32'(drop_count), 1);
        for (int i = 0; i < 300; i++) cyc();
        host_valid = 1'b0;
        chk("drop_sat", 32'(drop_count), 255);
        chk("drop_no_enable", en_cnt - en_mark, 0);
        chk("drop_level", 32'(fifo_level), 0);

        // Reset mid-operation: 3 queued, FSM in gap
        net_buffer_full = 1'b1;
        host_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            host_dest = 2'd3;
            host_payload = 6'(6'h10 + i);
            cyc();
        end
        host_valid = 1'b0;
        net_buffer_full = 1'b0;
        cyc();
        chk("mid_level3", 32'(fifo_level), 3);
        chk("mid_en_high", 32'(net_enable_out), 1);
        #1 rst = 1'b0;
        #1;
        chk("mid_en_async", 32'(net_enable_out), 0);
        chk("mid_level_clr", 32'(fifo_level), 0);
        chk("mid_ready", 32'(host_ready), 1);
        chk("mid_sent_clr", 32'(sent_count), 0);
        chk("mid_drop_clr", 32'(drop_count), 0);
        chk("mid_data_clr", 32'(net_data_out), 0);
        sb.delete();
        m_level = 0;
        m_sent = 0;
        m_drop = 0;
        last_en = -100;
        cyc();
        cyc();
        #1 rst = 1'b1;

        // Fresh packet after reset: {6'h2A, 2'd3} = 8'hAB
        host_valid = 1'b1;
        host_dest = 2'd3;
        host_payload = 6'h2A;
        en_mark = en_cnt;
        cyc();
        host_valid = 1'b0;
        chk("post_no_early_en", en_cnt - en_mark, 0);
        cyc();
        chk("post_latency", en_cnt - en_mark, 1);
        chk("post_data", 32'(net_data_out), 32'hAB);
        cyc();
        chk("post_sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
